// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ISSUE -> [WAIT] -> IDLE)
//   req_id_t    : requester identity, C = processor control FSM, H = host loader
//   MAX_RD_LAT  : largest supported RAM read latency
//   WAIT_CNT_W  : width of the read-latency down-counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_C = 1'b0,
    REQ_H = 1'b1
  } req_id_t;

  localparam int MAX_RD_LAT = 4;
  localparam int WAIT_CNT_W = $clog2(MAX_RD_LAT);

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick (purely combinational).
// Ports:
//   req[1:0]  in   request vector, bit 0 = C, bit 1 = H
//   last_id   in   requester granted most recently
//   win_id    out  chosen requester (only meaningful when any = 1)
//   any       out  at least one request present
// A lone request always wins; on a tie the requester that was not served
// last wins, which bounds every requester's wait to one foreign access.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_id,
  output req_id_t    win_id,
  output logic       any
);

  always_comb begin
    any    = |req;
    win_id = REQ_C;
    if (req == 2'b11) begin
      win_id = (last_id == REQ_C) ? REQ_H : REQ_C;
    end else if (req[1]) begin
      win_id = REQ_H;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the processor control FSM
// (requester C) and the host program loader (requester H). One access is in
// flight at a time; each requester gets its own grant and read-valid pulse.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata     processor request (held until c_gnt)
//   c_gnt, c_rvalid               processor grant / read-data-valid pulses
//   h_req/h_we/h_addr/h_wdata     host loader request (held until h_gnt)
//   h_gnt, h_rvalid               host loader grant / read-data-valid pulses
//   mem_q                         RAM read data
//   mem_addr/mem_wdata/mem_we     RAM address, write data, write enable
//   rdata                         read data to both requesters
//   busy                          arbiter not idle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be in 1..%0d", MAX_RD_LAT);
  end

  arb_state_t            state_q, state_d;
  req_id_t               last_id_q, last_id_d;
  req_id_t               sel_id_q, sel_id_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

  req_id_t               win_id;
  logic                  any_req;

  rr_pick2 u_pick (
    .req     ({h_req, c_req}),
    .last_id (last_id_q),
    .win_id  (win_id),
    .any     (any_req)
  );

  // Fields of the requester latched in IDLE. Requesters keep them stable
  // until granted, so muxing live inputs in ISSUE is safe.
  logic              sel_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign sel_req   = (sel_id_q == REQ_H) ? h_req   : c_req;
  assign sel_we    = (sel_id_q == REQ_H) ? h_we    : c_we;
  assign sel_addr  = (sel_id_q == REQ_H) ? h_addr  : c_addr;
  assign sel_wdata = (sel_id_q == REQ_H) ? h_wdata : c_wdata;

  // An ISSUE cycle whose winner has withdrawn does nothing at all.
  logic issue_ok;
  logic rd_done;

  assign issue_ok = (state_q == ARB_ISSUE) && sel_req;
  assign rd_done  = (state_q == ARB_WAIT) && (wait_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    sel_id_d    = sel_id_q;
    wait_cnt_d  = wait_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          sel_id_d = win_id;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (sel_req) begin
          last_id_d   = sel_id_q;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          if (sel_we) begin
            state_d = ARB_IDLE;
          end else begin
            state_d    = ARB_WAIT;
            wait_cnt_d = WAIT_CNT_W'(RD_LAT - 1);
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = ARB_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      last_id_q   <= REQ_H;
      sel_id_q    <= REQ_C;
      wait_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      sel_id_q    <= sel_id_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Per-requester pulses: only the latched requester can see a pulse.
  logic [1:0] gnt_vec;
  logic [1:0] rvalid_vec;

  for (genvar gi = 0; gi < 2; gi++) begin : g_pulse
    localparam req_id_t ID = (gi == 0) ? REQ_C : REQ_H;
    assign gnt_vec[gi]    = issue_ok && (sel_id_q == ID);
    assign rvalid_vec[gi] = rd_done && (sel_id_q == ID);
  end

  assign c_gnt    = gnt_vec[0];
  assign h_gnt    = gnt_vec[1];
  assign c_rvalid = rvalid_vec[0];
  assign h_rvalid = rvalid_vec[1];

  // The RAM sees the new address/data during the ISSUE cycle itself and the
  // held copy at every other time, so its inputs never wander between accesses.
  assign mem_addr  = issue_ok ? sel_addr  : mem_addr_q;
  assign mem_wdata = issue_ok ? sel_wdata : mem_wdata_q;
  assign mem_we    = issue_ok && sel_we;
  assign rdata     = mem_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 9;
  localparam int RD_LAT = 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_v   [2];
  logic              we_v    [2];
  logic [ADDR_W-1:0] addr_v  [2];
  logic [DATA_W-1:0] wdata_v [2];
  logic              c_gnt, c_rvalid, h_gnt, h_rvalid;
  logic [DATA_W-1:0] mem_q;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .c_req     (req_v[0]),
    .c_we      (we_v[0]),
    .c_addr    (addr_v[0]),
    .c_wdata   (wdata_v[0]),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .h_req     (req_v[1]),
    .h_we      (we_v[1]),
    .h_addr    (addr_v[1]),
    .h_wdata   (wdata_v[1]),
    .h_gnt     (h_gnt),
    .h_rvalid  (h_rvalid),
    .mem_q     (mem_q),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .rdata     (rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM stand-in, one-edge read latency, read-before-write.
  logic [DATA_W-1:0] ram [2**ADDR_W];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_q <= ram[mem_addr];
  end

  // Requester agents, scoreboard and reference memory contents.
  txn_t              agt_q [2][$];
  txn_t              exp_q [2][$];
  logic [DATA_W-1:0] rd_q  [2][$];
  logic [DATA_W-1:0] shadow [2**ADDR_W];
  bit                gnt_s [2];
  bit                kill  [2];
  int                gcyc  [2];
  int                cyc = 0;
  int                grant_log [$];
  int                checks = 0;
  int                errors = 0;
  string             nm [2] = '{"C", "H"};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_txn(input int id, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input bit scored);
    txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    agt_q[id].push_back(t);
    if (scored) begin
      exp_q[id].push_back(t);
      if (we) shadow[addr] = wdata;
      else    rd_q[id].push_back(shadow[addr]);
    end
  endtask

  // A granted requester retires its transaction and presents the next one
  // (or drops req) in the cycle right after the grant.
  task automatic drive_agents();
    txn_t t;
    for (int id = 0; id < 2; id++) begin
      if (gnt_s[id] && agt_q[id].size() > 0) void'(agt_q[id].pop_front());
      if (agt_q[id].size() > 0 && !kill[id]) begin
        t           = agt_q[id][0];
        req_v[id]   = 1'b1;
        we_v[id]    = t.we;
        addr_v[id]  = t.addr;
        wdata_v[id] = t.wdata;
      end else begin
        req_v[id] = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    txn_t              e;
    logic [DATA_W-1:0] d;
    bit                gnt_now [2];
    bit                rv_now  [2];
    cyc++;
    gnt_now[0] = c_gnt;
    gnt_now[1] = h_gnt;
    rv_now[0]  = c_rvalid;
    rv_now[1]  = h_rvalid;
    check("single_pulse", 32'($countones({c_gnt, h_gnt, c_rvalid, h_rvalid}) <= 1), 32'd1);
    check("we_outside_issue", 32'(mem_we && !(c_gnt || h_gnt)), 32'd0);
    for (int id = 0; id < 2; id++) begin
      if (gnt_now[id]) begin
        grant_log.push_back(id);
        gcyc[id] = cyc;
        if (exp_q[id].size() == 0) begin
          check($sformatf("%s_unexpected_gnt", nm[id]), 32'd1, 32'd0);
        end else begin
          e = exp_q[id].pop_front();
          check($sformatf("%s_gnt_fields", nm[id]), 32'({mem_we, mem_addr, mem_wdata}),
                32'({e.we, e.addr, e.wdata}));
          $display("cycle %0d: %s gnt %s addr=0x%02h wdata=0x%03h", cyc, nm[id],
                   e.we ? "write" : "read ", e.addr, e.wdata);
        end
      end
      if (rv_now[id]) begin
        if (rd_q[id].size() == 0) begin
          check($sformatf("%s_unexpected_rvalid", nm[id]), 32'd1, 32'd0);
        end else begin
          d = rd_q[id].pop_front();
          check($sformatf("%s_rdata", nm[id]), 32'(rdata), 32'(d));
          check($sformatf("%s_rd_latency", nm[id]), 32'(cyc - gcyc[id]), 32'(RD_LAT));
          $display("cycle %0d: %s rvalid rdata=0x%03h", cyc, nm[id], rdata);
        end
      end
      gnt_s[id] = gnt_now[id];
    end
  endtask

  task automatic tick(input bit rst_mid = 1'b0);
    @(posedge clk);
    #1;
    drive_agents();
    if (rst_mid) rst = 1'b0;
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_gnt(input int id, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!gnt_s[id] && n < max);
    if (!gnt_s[id]) check($sformatf("%s_gnt_timeout", nm[id]), 32'd0, 32'd1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    int pend;
    pend = exp_q[0].size() + exp_q[1].size() + rd_q[0].size() + rd_q[1].size();
    while (pend > 0 && n < max) begin
      tick();
      n++;
      pend = exp_q[0].size() + exp_q[1].size() + rd_q[0].size() + rd_q[1].size();
    end
    if (pend > 0) check("drain_timeout", 32'(pend), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    for (int id = 0; id < 2; id++) begin
      req_v[id]   = 1'b0;
      we_v[id]    = 1'b0;
      addr_v[id]  = '0;
      wdata_v[id] = '0;
      gnt_s[id]   = 1'b0;
      kill[id]    = 1'b0;
      gcyc[id]    = 0;
    end

    // 1. Reset held with both requesters pending; C takes the first tie.
    push_txn(0, 1'b1, 7'h20, 9'h055, 1'b1);
    push_txn(1, 1'b1, 7'h21, 9'h0AA, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("reset_outputs", 32'({c_gnt, h_gnt, c_rvalid, h_rvalid, mem_we, busy, mem_addr, mem_wdata}),
          32'd0);
    grant_log.delete();
    rst = 1'b1;
    drain(20);
    check("reset_grant_count", 32'(grant_log.size()), 32'd2);
    check("reset_first_grant", 32'(grant_log[0]), 32'(REQ_C));

    // 2. Lone C write: grant one cycle after the request appears.
    push_txn(0, 1'b1, 7'h05, 9'h1A3, 1'b1);
    wait_gnt(0, 10, n);
    check("c_wr_gnt_latency", 32'(n), 32'd2);
    check("c_wr_mem_we", 32'(mem_we), 32'd1);
    check("c_wr_mem_addr", 32'(mem_addr), 32'h05);
    tick();
    check("c_wr_busy_after", 32'(busy), 32'd0);

    // 3. H read of a location it just loaded.
    push_txn(1, 1'b1, 7'h10, 9'h0F0, 1'b1);
    drain(20);
    push_txn(1, 1'b0, 7'h10, 9'h000, 1'b1);
    wait_gnt(1, 10, n);
    check("h_rd_gnt_latency", 32'(n), 32'd2);
    check("h_rd_busy_issue", 32'(busy), 32'd1);
    tick();
    check("h_rd_rvalid", 32'(h_rvalid), 32'd1);
    check("h_rd_rdata", 32'(rdata), 32'h0F0);
    check("h_rd_busy_wait", 32'(busy), 32'd1);
    tick();
    check("h_rd_busy_after", 32'(busy), 32'd0);

    // 4. Both requesters continuously busy: strict alternation starting at C.
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      push_txn(0, 1'b1, 7'(8'h30 + i), 9'(9'h100 + 3 * i), 1'b1);
    end
    push_txn(1, 1'b0, 7'h05, 9'h000, 1'b1);
    push_txn(1, 1'b0, 7'h10, 9'h000, 1'b1);
    push_txn(1, 1'b0, 7'h20, 9'h000, 1'b1);
    drain(60);
    check("alt_grant_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < grant_log.size(); i++) begin
      check($sformatf("alt_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));
    end

    // 5. C withdraws during its ISSUE cycle: nothing reaches the RAM and the
    //    round-robin pointer is untouched, so the next tie still goes to C.
    push_txn(0, 1'b1, 7'h50, 9'h111, 1'b0);
    tick();
    kill[0] = 1'b1;
    tick();
    check("drop_busy_issue", 32'(busy), 32'd1);
    check("drop_no_gnt", 32'(c_gnt), 32'd0);
    check("drop_no_we", 32'(mem_we), 32'd0);
    check("drop_addr_held", 32'(mem_addr), 32'h20);
    agt_q[0].delete();
    kill[0] = 1'b0;
    tick();
    grant_log.delete();
    push_txn(0, 1'b1, 7'h51, 9'h0AB, 1'b1);
    push_txn(1, 1'b1, 7'h52, 9'h0CD, 1'b1);
    drain(20);
    check("drop_next_tie", 32'(grant_log[0]), 32'(REQ_C));

    // 6. Reset during an H read wait: the read never completes; H then
    //    re-requests and is served normally.
    push_txn(1, 1'b0, 7'h51, 9'h000, 1'b1);
    wait_gnt(1, 10, n);
    rd_q[1].delete();
    tick(1'b1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_no_rvalid", 32'(h_rvalid), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    push_txn(1, 1'b0, 7'h52, 9'h000, 1'b1);
    wait_gnt(1, 10, n);
    check("h_rerequest_latency", 32'(n), 32'd2);
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
